mbs_port_master: RTL and testbench

//  Initiator for one mbs request/response port of the ZBT SRAM controller.
//  - Accepts word commands from local logic on a valid/ready interface.
//  - The controller has no request ack and services each port in a 4-cycle

---
 rtl/mbs_port_master.sv | 119 +++++++++++
 tb/tb_mbs_port_master.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbs_port_master.sv
// rtl/mbs_port_master.sv - mbs port initiator: slot-length request hold, one outstanding read with timeout
// Requests are held for one full round-robin period because the controller gives no ack.
module mbs_port_master #(
   parameter int          HOLD_CYCLES    = 4,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
   input  logic        clk_sram,
   input  logic        rst_sram,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic        i_cmd_we,
   input  logic [17:0] i_cmd_adr,
   input  logic [31:0] i_cmd_wdata,
   input  logic [3:0]  i_cmd_be,
   output logic [17:0] o_mbs_req_adr,
   output logic        o_mbs_req_we,
   output logic [31:0] o_mbs_req_wdata,
   output logic [3:0]  o_mbs_req_be,
   output logic        o_mbs_req_valid,
   input  logic [31:0] i_mbs_resp_rdata,
   input  logic        i_mbs_resp_valid,
   output logic [31:0] o_rd_data,
   output logic        o_rd_valid,
   output logic        o_rd_err
);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_RD_DRAIN} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [HW-1:0] r_hold_cnt;
   logic [TW-1:0] r_to_cnt;
   logic          w_hold_last;
   logic          w_to_last;
   logic          w_accept;

   assign w_hold_last = (r_hold_cnt == HOLD_LAST);
   assign w_to_last   = (r_to_cnt == TO_LAST);
   assign w_accept    = i_cmd_valid & o_cmd_ready;

   always_ff @(posedge clk_sram or posedge rst_sram) begin
      if (rst_sram) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_accept) w_state_nxt = S_ISSUE;
         S_ISSUE:
            if (w_hold_last) begin
               if (!o_mbs_req_we)  w_state_nxt = S_RD_WAIT;
               else if (!w_accept) w_state_nxt = S_IDLE;
            end
         S_RD_WAIT:  if (i_mbs_resp_valid || w_to_last) w_state_nxt = S_RD_DRAIN;
         S_RD_DRAIN: if (!i_mbs_resp_valid) w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // Ready depends only on state, so it never follows i_cmd_valid combinationally.
   always_comb begin
      o_cmd_ready = 1'b0;
      case (r_state)
         S_IDLE:  o_cmd_ready = 1'b1;
         S_ISSUE: o_cmd_ready = o_mbs_req_we & w_hold_last;
         default: o_cmd_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk_sram or posedge rst_sram) begin
      if (rst_sram) begin
         o_mbs_req_adr   <= '0;
         o_mbs_req_we    <= 1'b0;
         o_mbs_req_wdata <= '0;
         o_mbs_req_be    <= '0;
         o_mbs_req_valid <= 1'b0;
         o_rd_data       <= '0;
         o_rd_valid      <= 1'b0;
         o_rd_err        <= 1'b0;
         r_hold_cnt      <= '0;
         r_to_cnt        <= '0;
      end else begin
         o_rd_valid <= 1'b0;
         o_rd_err   <= 1'b0;
         if (w_accept) begin
            o_mbs_req_adr   <= i_cmd_adr;
            o_mbs_req_we    <= i_cmd_we;
            o_mbs_req_wdata <= i_cmd_wdata;
            o_mbs_req_be    <= i_cmd_be;
            o_mbs_req_valid <= 1'b1;
            r_hold_cnt      <= '0;
         end else if (r_state == S_ISSUE) begin
            if (w_hold_last) o_mbs_req_valid <= 1'b0;
            else             r_hold_cnt      <= r_hold_cnt + 1'b1;
         end
         // A response arriving on the timeout cycle still delivers its data.
         if (r_state == S_RD_WAIT) begin
            if (i_mbs_resp_valid) begin
               o_rd_data  <= i_mbs_resp_rdata;
               o_rd_valid <= 1'b1;
            end else if (w_to_last) begin
               o_rd_data  <= ERR_DATA;
               o_rd_valid <= 1'b1;
               o_rd_err   <= 1'b1;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end else begin
            r_to_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_mbs_port_master.sv
// tb/tb_mbs_port_master.sv - bench for mbs_port_master with a slot-based controller model
module tb_mbs_port_master;
   logic        clk_sram = 1'b0;
   logic        rst_sram;
   logic        i_cmd_valid, o_cmd_ready, i_cmd_we;
   logic [17:0] i_cmd_adr;
   logic [31:0] i_cmd_wdata;
   logic [3:0]  i_cmd_be;
   logic [17:0] o_mbs_req_adr;
   logic        o_mbs_req_we, o_mbs_req_valid;
   logic [31:0] o_mbs_req_wdata;
   logic [3:0]  o_mbs_req_be;
   logic [31:0] i_mbs_resp_rdata;
   logic        i_mbs_resp_valid;
   logic [31:0] o_rd_data;
   logic        o_rd_valid, o_rd_err;

   always #5 clk_sram = ~clk_sram;

   mbs_port_master #(.HOLD_CYCLES(4), .TIMEOUT_CYCLES(64), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk_sram(clk_sram), .rst_sram(rst_sram),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_we(i_cmd_we),
      .i_cmd_adr(i_cmd_adr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_be(i_cmd_be),
      .o_mbs_req_adr(o_mbs_req_adr), .o_mbs_req_we(o_mbs_req_we),
      .o_mbs_req_wdata(o_mbs_req_wdata), .o_mbs_req_be(o_mbs_req_be),
      .o_mbs_req_valid(o_mbs_req_valid),
      .i_mbs_resp_rdata(i_mbs_resp_rdata), .i_mbs_resp_valid(i_mbs_resp_valid),
      .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_err(o_rd_err)
   );

   typedef struct { logic [31:0] data; logic err; } rd_exp_t;
   typedef struct {
      bit          we;
      logic [17:0] adr;
      logic [31:0] wdata;
      logic [3:0]  be;
      bit          resp;
      logic [31:0] exp_data;
      bit          exp_err;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   rd_exp_t exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic bound_expired(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired, got no event, expected one", name);
   endtask

   // Reference memory, updated when a write command is accepted.
   bit [31:0] ref_mem [65536];

   task automatic ref_write(input logic [17:0] adr, input logic [31:0] wd, input logic [3:0] be);
      int idx = int'(adr[17:2]);
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
   endtask

   // Controller model: port owns slot 0 of a 4-cycle round robin.
   bit        resp_en    = 1'b1;
   int        resp_delay = 2;
   int        resp_len   = 4;
   bit [31:0] ctl_mem [65536];
   int        wr_count = 0;
   int        ctl_slot, ctl_dly, ctl_left;
   bit        ctl_pend;
   logic [31:0] ctl_data;

   initial begin
      int idx;
      i_mbs_resp_valid = 1'b0;
      i_mbs_resp_rdata = '0;
      forever begin
         @(negedge clk_sram);
         if (rst_sram) begin
            ctl_slot = 0; ctl_pend = 1'b0; ctl_left = 0; i_mbs_resp_valid = 1'b0;
         end else begin
            if (ctl_slot == 0 && o_mbs_req_valid) begin
               idx = int'(o_mbs_req_adr[17:2]);
               if (o_mbs_req_we) begin
                  for (int b = 0; b < 4; b++)
                     if (o_mbs_req_be[b]) ctl_mem[idx][8*b +: 8] = o_mbs_req_wdata[8*b +: 8];
                  wr_count++;
               end else if (resp_en) begin
                  ctl_pend = 1'b1; ctl_dly = resp_delay; ctl_data = ctl_mem[idx];
               end
            end
            ctl_slot = (ctl_slot + 1) % 4;
            if (ctl_left > 0) begin
               ctl_left--;
               if (ctl_left == 0) begin
                  i_mbs_resp_valid = 1'b0;
                  i_mbs_resp_rdata = $urandom;
               end
            end else if (ctl_pend) begin
               if (ctl_dly == 0) begin
                  i_mbs_resp_valid = 1'b1; i_mbs_resp_rdata = ctl_data;
                  ctl_left = resp_len; ctl_pend = 1'b0;
               end else ctl_dly--;
            end
         end
      end
   end

   // Request-valid run tracker.
   logic [17:0] run_adr[$];
   int run_len = 0, last_run = 0;
   bit in_run = 1'b0;
   initial forever begin
      @(negedge clk_sram);
      if (rst_sram) begin
         in_run = 1'b0; run_len = 0;
      end else if (o_mbs_req_valid) begin
         if (!in_run) begin run_adr.delete(); run_len = 0; end
         run_len++;
         run_adr.push_back(o_mbs_req_adr);
         in_run = 1'b1;
      end else if (in_run) begin
         last_run = run_len; in_run = 1'b0;
      end
   end

   // Read-result monitor.
   int n_pulses = 0;
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk_sram);
         if (!rst_sram) begin
            if (o_rd_valid) begin
               n_pulses++;
               if (exp_q.size() == 0) begin
                  check("rd_unexpected_pulse", {31'd0, o_rd_valid}, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("rd_data", o_rd_data, e.data);
                  check("rd_err", o_rd_err, e.err);
               end
            end
            if (i_mbs_resp_valid) check("ready_during_resp", o_cmd_ready, 0);
         end
      end
   end

   bit acc_resp_valid;

   task automatic send(input bit we, input logic [17:0] adr, input logic [31:0] wd, input logic [3:0] be);
      int n = 0;
      i_cmd_valid = 1'b1; i_cmd_we = we; i_cmd_adr = adr; i_cmd_wdata = wd; i_cmd_be = be;
      while (!o_cmd_ready && n < 300) begin @(negedge clk_sram); n++; end
      if (!o_cmd_ready) begin
         bound_expired("cmd_accept");
         i_cmd_valid = 1'b0;
         return;
      end
      acc_resp_valid = i_mbs_resp_valid;
      if (we) ref_write(adr, wd, be);
      @(negedge clk_sram);
   endtask

   task automatic wait_rd_done();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge clk_sram); n++; end
      if (exp_q.size() != 0) begin
         bound_expired("rd_complete");
         exp_q.delete();
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!o_cmd_ready && n < 300) begin @(negedge clk_sram); n++; end
      if (!o_cmd_ready) bound_expired("ready_return");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[9];
      logic [17:0] b2b_adr[3];
      int          w0, p0, n, n_rd;
      bit          ok, we;
      logic [17:0] adr;

      tbl[0] = '{1'b1, 18'h00104, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0,         1'b0};
      tbl[1] = '{1'b0, 18'h00104, 32'h0,         4'h0, 1'b1, 32'hA5A5_0001, 1'b0};
      tbl[2] = '{1'b1, 18'h00108, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         1'b0};
      tbl[3] = '{1'b1, 18'h0010A, 32'hFFFF_FFFF, 4'h2, 1'b0, 32'h0,         1'b0};
      tbl[4] = '{1'b0, 18'h00108, 32'h0,         4'h0, 1'b1, 32'h1234_FF78, 1'b0};
      tbl[5] = '{1'b0, 18'h00107, 32'h0,         4'h0, 1'b1, 32'hA5A5_0001, 1'b0};
      tbl[6] = '{1'b1, 18'h3FFFF, 32'hCAFE_F00D, 4'h9, 1'b0, 32'h0,         1'b0};
      tbl[7] = '{1'b0, 18'h3FFFC, 32'h0,         4'h0, 1'b1, 32'hCA00_000D, 1'b0};
      tbl[8] = '{1'b0, 18'h00200, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1};

      rst_sram = 1'b1;
      i_cmd_valid = 1'b0; i_cmd_we = 1'b0; i_cmd_adr = '0; i_cmd_wdata = '0; i_cmd_be = '0;
      repeat (3) @(negedge clk_sram);
      check("rst_req_valid", o_mbs_req_valid, 0);
      check("rst_req_adr", o_mbs_req_adr, 0);
      check("rst_req_we", o_mbs_req_we, 0);
      check("rst_rd_valid", o_rd_valid, 0);
      check("rst_rd_err", o_rd_err, 0);
      check("rst_rd_data", o_rd_data, 0);
      rst_sram = 1'b0;
      #1 check("idle_ready", o_cmd_ready, 1);
      @(negedge clk_sram);

      // Single write: four-cycle hold with constant fields.
      w0 = wr_count; p0 = n_pulses;
      send(1'b1, 18'h00104, 32'hA5A5_0001, 4'hF);
      i_cmd_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk_sram);
      check("wr_hold_len", last_run, 4);
      ok = 1'b1;
      foreach (run_adr[k]) if (run_adr[k] !== 18'h00104) ok = 1'b0;
      check("wr_fields_const", ok, 1);
      check("wr_ctl_count", wr_count - w0, 1);
      check("wr_no_rd_pulse", n_pulses - p0, 0);

      // Table of commands.
      p0 = n_pulses; n_rd = 0;
      for (int i = 0; i < 9; i++) begin
         if (!tbl[i].we) begin
            resp_en = tbl[i].resp; resp_delay = 2; resp_len = 4;
            exp_q.push_back('{tbl[i].exp_data, tbl[i].exp_err});
            n_rd++;
         end
         send(tbl[i].we, tbl[i].adr, tbl[i].wdata, tbl[i].be);
         i_cmd_valid = 1'b0;
         if (!tbl[i].we) wait_rd_done();
         wait_idle();
      end
      check("tbl_rd_pulses", n_pulses - p0, n_rd);

      // Three back-to-back writes.
      b2b_adr[0] = 18'h00300; b2b_adr[1] = 18'h00304; b2b_adr[2] = 18'h00308;
      w0 = wr_count;
      for (int i = 0; i < 3; i++) send(1'b1, b2b_adr[i], 32'h1111_0000 * (i + 1), 4'hF);
      i_cmd_valid = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk_sram);
      check("b2b_hold_len", last_run, 12);
      ok = (run_adr.size() == 12);
      foreach (run_adr[k]) if (k < 12 && run_adr[k] !== b2b_adr[k/4]) ok = 1'b0;
      check("b2b_fields", ok, 1);
      check("b2b_ctl_count", wr_count - w0, 3);

      // Timeout timing: pulse on the 64th cycle in RD_WAIT.
      resp_en = 1'b0;
      exp_q.push_back('{32'hDEAD_BEEF, 1'b1});
      send(1'b0, 18'h00200, 32'h0, 4'h0);
      i_cmd_valid = 1'b0;
      n = 0;
      while (!o_rd_valid && n < 200) begin @(negedge clk_sram); n++; end
      if (!o_rd_valid) bound_expired("timeout_pulse");
      check("timeout_latency", n, 68);
      check("timeout_err", o_rd_err, 1);
      check("timeout_data", o_rd_data, 32'hDEAD_BEEF);
      @(negedge clk_sram);
      check("timeout_pulse_len", o_rd_valid, 0);
      check("timeout_back_idle", o_cmd_ready, 1);

      // Two reads; the first response is stretched over the second issue attempt.
      resp_en = 1'b1; resp_delay = 1; resp_len = 12;
      p0 = n_pulses;
      exp_q.push_back('{32'hA5A5_0001, 1'b0});
      exp_q.push_back('{32'h1234_FF78, 1'b0});
      send(1'b0, 18'h00104, 32'h0, 4'h0);
      send(1'b0, 18'h00108, 32'h0, 4'h0);
      check("overlap_issue_after_resp", acc_resp_valid, 0);
      i_cmd_valid = 1'b0;
      wait_rd_done();
      wait_idle();
      check("overlap_pulses", n_pulses - p0, 2);
      resp_len = 4; resp_delay = 2;

      // Reset during hold cycle 2 of a read.
      resp_en = 1'b0;
      send(1'b0, 18'h00400, 32'h0, 4'h0);
      i_cmd_valid = 1'b0;
      @(negedge clk_sram);
      #2 rst_sram = 1'b1;
      #1 check("async_rst_valid", o_mbs_req_valid, 0);
      @(negedge clk_sram);
      rst_sram = 1'b0;
      #1 check("post_rst_ready", o_cmd_ready, 1);
      p0 = n_pulses;
      repeat (80) @(negedge clk_sram);
      check("post_rst_no_rd", n_pulses - p0, 0);

      // Randomised traffic against the reference memory.
      p0 = n_pulses; n_rd = 0;
      for (int i = 0; i < 40; i++) begin
         we  = ($urandom % 10) < 6;
         adr = 18'h00800 + 18'(($urandom % 16) * 4) + 18'($urandom % 4);
         if (!we) begin
            resp_en    = ($urandom % 5) != 0;
            resp_delay = $urandom_range(1, 8);
            resp_len   = $urandom_range(4, 7);
            exp_q.push_back(resp_en ? '{ref_mem[int'(adr[17:2])], 1'b0} : '{32'hDEAD_BEEF, 1'b1});
            n_rd++;
            send(1'b0, adr, 32'h0, 4'h0);
            i_cmd_valid = 1'b0;
            wait_rd_done();
         end else begin
            send(1'b1, adr, $urandom, 4'($urandom_range(1, 15)));
            if ($urandom % 2) begin i_cmd_valid = 1'b0; @(negedge clk_sram); end
         end
      end
      i_cmd_valid = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk_sram);
      check("rand_rd_pulses", n_pulses - p0, n_rd);
      check("exp_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
